// File: rtl/adc_sample_scheduler.sv
// Paced / on-demand ADC conversion sequencer feeding a CPU-drained sample FIFO with sticky error flags.
// Optional: define ADC_SCHED_AVG_EN to store the mean of four back-to-back conversions per sample.
module adc_sample_scheduler #(
    parameter int SAMPLE_DIV     = 12000,
    parameter int FIFO_DEPTH     = 16,
    parameter int ADC_WIDTH      = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk12MHz,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          single_shot,
    input  logic                          clear_flags,
    output logic                          adc_start,
    input  logic                          adc_done,
    input  logic [ADC_WIDTH-1:0]          adc_value,
    input  logic                          rd_en,
    output logic [ADC_WIDTH-1:0]          rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          empty,
    output logic                          busy,
    output logic                          overflow,
    output logic                          overrun,
    output logic                          timeout
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = 24;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(SAMPLE_DIV - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_STORE = 2'd3;

    logic [1:0]           state;
    logic [DW-1:0]        div_cnt;
    logic                 tick;
    logic [TW-1:0]        tmo_cnt;
    logic                 tmo_hit;
    logic [ADC_WIDTH-1:0] sample;
    logic [ADC_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 full;
    logic                 do_read;
    logic                 do_write;
    logic                 store_drop;

`ifdef ADC_SCHED_AVG_EN
    logic [ADC_WIDTH+1:0] acc;
    logic [ADC_WIDTH+1:0] acc_next;
    logic [1:0]           conv_idx;
    assign acc_next = acc + {2'b00, adc_value};
`endif

    assign tick      = enable && (div_cnt == DIV_LAST);
    assign tmo_hit   = (state == S_WAIT) && !adc_done && (tmo_cnt == TMO_LAST);
    assign adc_start = (state == S_START);
    assign busy      = (state != S_IDLE);

    // Divider only runs while periodic sampling is enabled and restarts from zero when re-enabled.
    always_ff @(posedge clk12MHz) begin
        if (reset || !enable || (div_cnt == DIV_LAST)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
            sample  <= '0;
`ifdef ADC_SCHED_AVG_EN
            acc      <= '0;
            conv_idx <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (tick || single_shot) begin
                        state <= S_START;
`ifdef ADC_SCHED_AVG_EN
                        acc      <= '0;
                        conv_idx <= '0;
`endif
                    end
                end
                S_START: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (adc_done) begin
`ifdef ADC_SCHED_AVG_EN
                        // Fourth result completes the sum; earlier ones go back for another request.
                        if (conv_idx == 2'd3) begin
                            sample <= acc_next[ADC_WIDTH+1:2];
                            state  <= S_STORE;
                        end else begin
                            acc      <= acc_next;
                            conv_idx <= conv_idx + 2'd1;
                            state    <= S_START;
                        end
`else
                        sample <= adc_value;
                        state  <= S_STORE;
`endif
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A pop frees a slot in the same cycle, so a store into a full FIFO still succeeds alongside it.
    assign full       = (fifo_count == FULL_COUNT);
    assign empty      = (fifo_count == '0);
    assign do_read    = rd_en && !empty;
    assign do_write   = (state == S_STORE) && (!full || do_read);
    assign store_drop = (state == S_STORE) && full && !do_read;

    always_ff @(posedge clk12MHz) begin
        if (do_write) begin
            mem[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rd_data    <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            if (do_write && !do_read) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (do_read && !do_write) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Sticky flags: a set event in the same cycle as clear_flags keeps the flag high.
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            overflow <= 1'b0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            overflow <= store_drop | (overflow & ~clear_flags);
            overrun  <= (tick && (state != S_IDLE)) | (overrun & ~clear_flags);
            timeout  <= tmo_hit | (timeout & ~clear_flags);
        end
    end
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Scoreboard bench for adc_sample_scheduler: directed vectors, queued expected pops, behavioural ADC model.
`timescale 1ns/1ps
module tb_adc_sample_scheduler;
    logic       clk12MHz = 1'b0;
    logic       reset;
    logic       enable;
    logic       single_shot;
    logic       clear_flags;
    logic       adc_start;
    logic       adc_done;
    logic [9:0] adc_value;
    logic       rd_en;
    logic [9:0] rd_data;
    logic [4:0] fifo_count;
    logic       empty;
    logic       busy;
    logic       overflow;
    logic       overrun;
    logic       timeout;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;
    int model_delay = 3;
    int pending = 0;
    logic [9:0] model_value = 10'h155;
    logic [9:0] adc_vals [$];
    logic [9:0] exp_q [$];

    always #5 clk12MHz = ~clk12MHz;

    adc_sample_scheduler #(
        .SAMPLE_DIV(16), .FIFO_DEPTH(16), .ADC_WIDTH(10), .TIMEOUT_CYCLES(4096)
    ) dut (
        .clk12MHz(clk12MHz), .reset(reset), .enable(enable), .single_shot(single_shot),
        .clear_flags(clear_flags), .adc_start(adc_start), .adc_done(adc_done),
        .adc_value(adc_value), .rd_en(rd_en), .rd_data(rd_data), .fifo_count(fifo_count),
        .empty(empty), .busy(busy), .overflow(overflow), .overrun(overrun), .timeout(timeout)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ADC model: answers model_delay cycles after seeing adc_start; delay 0 means never answer.
    initial begin
        adc_done  = 1'b0;
        adc_value = '0;
        forever begin
            @(posedge clk12MHz);
            #1;
            adc_done = 1'b0;
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    adc_done  = 1'b1;
                    adc_value = (adc_vals.size() > 0) ? adc_vals.pop_front() : model_value;
                end
            end else if (adc_start && model_delay > 0) begin
                pending = model_delay;
            end
        end
    end

    always @(negedge clk12MHz) begin
        if (adc_start) start_cnt++;
    end

    // Monitor: every rd_en pulse consumes one expected rd_data value from the scoreboard.
    always @(posedge clk12MHz) begin
        logic [9:0] expv;
        if (rd_en) begin
            #1;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL rd_data: unexpected pop, got 0x%0h, expected none", rd_data);
            end else begin
                expv = exp_q.pop_front();
                checkOutput("rd_data", rd_data, expv);
            end
        end
    end

    task automatic applyStimulus(input logic ss, input logic cf);
        single_shot = ss;
        clear_flags = cf;
        @(negedge clk12MHz);
        single_shot = 1'b0;
        clear_flags = 1'b0;
    endtask

    task automatic popSample(input logic [9:0] expv);
        exp_q.push_back(expv);
        rd_en = 1'b1;
        @(negedge clk12MHz);
        rd_en = 1'b0;
    endtask

    task automatic waitStart(input int budget, output int waited, output int busy_seen);
        waited = 0;
        busy_seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk12MHz);
            waited++;
            if (adc_start) return;
            busy_seen += int'(busy);
        end
        tests++;
        fails++;
        $display("[TB] FAIL wait_start: no adc_start within %0d cycles, expected one", budget);
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (3) @(negedge clk12MHz);
        reset = 1'b0;
    endtask

    initial begin
        int w;
        int b;
        int s0;
        int n;
        reset = 1'b1;
        enable = 1'b0;
        single_shot = 1'b0;
        clear_flags = 1'b0;
        rd_en = 1'b0;
        @(negedge clk12MHz);
        doReset();

        checkOutput("reset_adc_start", adc_start, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_empty", empty, 1);
        checkOutput("reset_count", fifo_count, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_overrun", overrun, 0);
        checkOutput("reset_timeout", timeout, 0);
        checkOutput("reset_rd_data", rd_data, 0);

`ifndef ADC_SCHED_AVG_EN
        // Periodic sampling: one request every 16 cycles, busy for 5 cycles each.
        model_delay = 3;
        model_value = 10'h155;
        enable = 1'b1;
        waitStart(40, w, b);
        waitStart(40, w, b);
        checkOutput("period", w, 16);
        checkOutput("busy_len", b + 1, 5);
        waitStart(40, w, b);
        checkOutput("period2", w, 16);
        enable = 1'b0;
        repeat (8) @(negedge clk12MHz);
        checkOutput("periodic_count", fifo_count, 3);
        for (int i = 0; i < 3; i++) popSample(10'h155);
        checkOutput("periodic_empty", empty, 1);

        // Single shot with sampling disabled.
        model_value = 10'h3FF;
        s0 = start_cnt;
        applyStimulus(1'b1, 1'b0);
        repeat (10) @(negedge clk12MHz);
        checkOutput("single_starts", start_cnt - s0, 1);
        checkOutput("single_count", fifo_count, 1);
        popSample(10'h3FF);
        checkOutput("single_empty", empty, 1);

        // Fill, then overflow on the 17th conversion.
        for (int v = 1; v <= 16; v++) begin
            model_value = 10'(v);
            applyStimulus(1'b1, 1'b0);
            repeat (8) @(negedge clk12MHz);
        end
        checkOutput("full_count", fifo_count, 16);
        checkOutput("full_no_overflow", overflow, 0);
        model_value = 10'h011;
        applyStimulus(1'b1, 1'b0);
        repeat (8) @(negedge clk12MHz);
        checkOutput("ovf_count", fifo_count, 16);
        checkOutput("ovf_flag", overflow, 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("ovf_cleared", overflow, 0);

        // Pop coincident with STORE on a full FIFO: both happen, oldest comes out first.
        model_value = 10'h020;
        applyStimulus(1'b1, 1'b0);
        repeat (4) @(negedge clk12MHz);
        popSample(10'h001);
        repeat (4) @(negedge clk12MHz);
        checkOutput("coincident_count", fifo_count, 16);
        checkOutput("coincident_overflow", overflow, 0);
        for (int v = 2; v <= 16; v++) popSample(10'(v));
        popSample(10'h020);
        checkOutput("drained_count", fifo_count, 0);
        checkOutput("drained_empty", empty, 1);
        popSample(10'h020);
        checkOutput("empty_pop_count", fifo_count, 0);

        // ADC never answers: timeout after 4096 cycles in WAIT.
        model_delay = 0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("tmo_start_seen", adc_start, 1);
        n = 0;
        for (int i = 1; i <= 5000; i++) begin
            @(negedge clk12MHz);
            if (timeout) begin
                n = i;
                break;
            end
        end
        checkOutput("tmo_latency", n, 4097);
        checkOutput("tmo_busy", busy, 0);
        checkOutput("tmo_count", fifo_count, 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("tmo_cleared", timeout, 0);

        // Slow ADC: periodic tick during WAIT is dropped and flags overrun.
        model_delay = 20;
        model_value = 10'h2AA;
        enable = 1'b1;
        waitStart(40, w, b);
        waitStart(60, w, b);
        checkOutput("overrun_period", w, 32);
        checkOutput("overrun_flag", overrun, 1);
        enable = 1'b0;
        repeat (30) @(negedge clk12MHz);
        checkOutput("overrun_count", fifo_count, 2);
        popSample(10'h2AA);
        popSample(10'h2AA);

        // Reset mid-conversion; the late adc_done must not store anything.
        model_delay = 10;
        model_value = 10'h0AB;
        applyStimulus(1'b1, 1'b0);
        repeat (3) @(negedge clk12MHz);
        doReset();
        repeat (15) @(negedge clk12MHz);
        checkOutput("midreset_count", fifo_count, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_overrun", overrun, 0);
`else
        // Averaging: four conversions per stored sample.
        model_delay = 3;
        adc_vals.push_back(10'h100);
        adc_vals.push_back(10'h101);
        adc_vals.push_back(10'h102);
        adc_vals.push_back(10'h104);
        s0 = start_cnt;
        applyStimulus(1'b1, 1'b0);
        repeat (30) @(negedge clk12MHz);
        checkOutput("avg_starts", start_cnt - s0, 4);
        checkOutput("avg_count", fifo_count, 1);
        popSample(10'h101);

        // Reset during the third conversion discards the partial sample.
        for (int i = 0; i < 4; i++) adc_vals.push_back(10'h200);
        applyStimulus(1'b1, 1'b0);
        waitStart(20, w, b);
        checkOutput("avg_busy_between", b, 3);
        waitStart(20, w, b);
        repeat (2) @(negedge clk12MHz);
        doReset();
        repeat (20) @(negedge clk12MHz);
        adc_vals.delete();
        checkOutput("avg_reset_count", fifo_count, 0);
        checkOutput("avg_reset_busy", busy, 0);
`endif
        repeat (3) @(negedge clk12MHz);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end
endmodule
